raw10_unpacker: RTL and testbench
=================================

Name: raw10_unpacker

Overview:
- Sits directly downstream of the CSI packet handler FSM.
- Consumes its 16-bit payload beat stream (out_stream / frame_valid / last_packet) for RAW10 long packets.
- Unpacks the 5-byte RAW10 groups into four 10-bit pixels and emits one 40-bit pixel quad per completed group, with start-of-line and end-of-frame markers, for the downstream pixel/frame-buffer logic.

Parameters:
- DATA_STREAM_WIDTH, 16: input beat width. Only 16 (two bytes per beat) is supported.
- LOW_BYTE_FIRST, 1: 1 = in_stream[7:0] is the earlier byte of the beat; 0 = in_stream[15:8] is earlier.

Ports:
- rxbyteclkhs  input  1  byte clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_stream  input  16  payload beat (upstream out_stream).
- in_valid  input  1  beat valid (upstream frame_valid). High continuously for one line; a low cycle ends the line.
- in_last  input  1  final beat of the final line of the frame (upstream last_packet).
- pix_data  output  40  {P3,P2,P1,P0}, each 10 bits; P0 in [9:0].
- pix_valid  output  1  one-cycle strobe, pix_data valid.
- pix_sol  output  1  qualifies pix_valid: first quad of a line.
- pix_eof  output  1  qualifies pix_valid: quad completed on an in_last beat.
- resid_err  output  1  one-cycle pulse: line ended with 2..4 unconsumed bytes.

Behaviour:
- Reset: all outputs 0, byte count 0, first_quad flag set, accumulator cleared.
  - Reset mid-line discards partial bytes.
  - Beats in the reset cycle are ignored.
- RAW10 group of bytes B0..B4:
  - Pn[9:2] = Bn for n = 0..3.
  - P0[1:0] = B4[1:0], P1[1:0] = B4[3:2], P2[1:0] = B4[5:4], P3[1:0] = B4[7:6].
- Byte ordering within a beat is set by LOW_BYTE_FIRST. The earlier byte takes the lower group index.
- Accumulator:
  - Up to 6 byte slots with held count cnt in 0..4.
  - Each in_valid beat appends 2 bytes: n = cnt + 2.
  - If n >= 5: emit B0..B4, shift the leftover byte (n - 5, i.e. 0 or 1) to slot 0, cnt <= n - 5.
  - Otherwise cnt <= n.
- Steady state repeats every 5 beats: cnt sequence 0→2→4→1(emit)→3→0(emit). At most one quad per cycle.
- Latency: pix_valid is registered and asserts in the cycle after the beat that supplies the 5th byte. Outputs hold their value between strobes. pix_sol and pix_eof are 0 whenever pix_valid is 0.
- State machine IDLE / LINE:
  - IDLE→LINE on in_valid=1. That beat is consumed and first_quad is set.
  - LINE→LINE while in_valid=1.
  - LINE→IDLE on in_valid=0. Residual is then evaluated:
    - cnt = 0: clean end.
    - cnt = 1: padding byte from an odd-length packet, dropped silently.
    - cnt 2..4: dropped, resid_err pulses in the next cycle.
  - cnt is cleared to 0 on entering IDLE.
- pix_sol = 1 on the first quad emitted after IDLE→LINE; first_quad then clears.
- pix_eof = 1 when the emitting beat had in_last = 1. An in_last beat that does not complete a group produces no eof marker.
- in_last with in_valid = 0 is ignored.
- Simultaneous events:
  - A line ending with cnt ≥ 2 sets resid_err, which may coincide with IDLE→LINE of the next line only if in_valid drops for exactly one cycle.
  - Both are handled independently; the new line starts with cnt = 0.

Optional Feature:
- Macro RAW10_LINE_CNT_EN.
- Defined: adds outputs line_quads [15:0] and line_done [0:0].
  - A counter increments per emitted quad and clears at IDLE→LINE.
  - On LINE→IDLE, line_quads registers the final count and line_done pulses for one cycle, aligned with resid_err.
  - Both outputs reset to 0.
- Undefined: ports and counter absent; all other behaviour identical.

Test Plan:
- Reset, then 5-beat line with bytes 00..09, LOW_BYTE_FIRST=1 → two pix_valid strobes on beat3+1 and beat5+1.
  - First quad: P0..P3 = {0x000 | B4[1:0]...}, computed from B4=0x04. Second quad from bytes 05..09.
  - pix_sol only on the first strobe. resid_err=0.
- Bytes FF,FF,FF,FF,FF → P0..P3 all 0x3FF. Bytes 80,40,20,10,E4 → P0=0x200, P1=0x101, P2=0x082, P3=0x043.
- 3-beat line of 6 bytes (one quad + 1 residual) → one quad, no resid_err. 4-beat line (8 bytes, cnt=3 at end) → one quad, resid_err pulse 1 cycle after in_valid falls.
- Final line with in_last on 5th beat → second quad carries pix_eof=1. Same line with in_last on 4th beat → no pix_eof.
- Assert reset after beat 2 of a line, then new 5-beat line → first quad uses only new bytes, pix_sol=1.
- With RAW10_LINE_CNT_EN: 10-beat line → line_quads=4 and line_done pulse 1 cycle after in_valid falls.

Source files
------------

// File: rtl/raw10_unpacker.sv
// raw10_unpacker: turns the 16-bit CSI payload beat stream into 40-bit RAW10
// pixel quads {P3,P2,P1,P0}, tagged with start-of-line and end-of-frame.
// Each 5-byte group gives four pixels: Pn[9:2] = Bn, Pn[1:0] = B4[2n+1:2n].
// Optional feature macro: RAW10_LINE_CNT_EN adds line_quads / line_done,
// which report the number of quads emitted per line.
module raw10_unpacker #(
    parameter int DATA_STREAM_WIDTH = 16,
    parameter bit LOW_BYTE_FIRST    = 1'b1
) (
    input  logic                         rxbyteclkhs,
    input  logic                         reset,
    input  logic [DATA_STREAM_WIDTH-1:0] in_stream,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic [39:0]                  pix_data,
    output logic                         pix_valid,
    output logic                         pix_sol,
    output logic                         pix_eof,
    output logic                         resid_err
`ifdef RAW10_LINE_CNT_EN
    ,
    output logic [15:0]                  line_quads,
    output logic [0:0]                   line_done
`endif
);

    typedef enum logic {IDLE, LINE} state_t;

    state_t      state;
    logic [2:0]  cnt;          // bytes held in acc, 0..4
    logic [7:0]  acc [4];
    logic        first_quad;

    logic [7:0]  byte_early;
    logic [7:0]  byte_late;
    logic [7:0]  ext [6];      // held bytes followed by this beat's two bytes
    logic [2:0]  n;
    logic        emit;
    logic        fq_eff;
    logic [39:0] quad;

`ifdef RAW10_LINE_CNT_EN
    logic [15:0] quad_cnt;
`endif

    // Split the beat into its earlier and later byte.
    always_comb begin
        if (LOW_BYTE_FIRST) begin
            byte_early = in_stream[7:0];
            byte_late  = in_stream[15:8];
        end else begin
            byte_early = in_stream[15:8];
            byte_late  = in_stream[7:0];
        end
    end

    // Append the new bytes behind the held ones and build the candidate quad.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            ext[i] = 8'h00;
            if (i < 4 && 3'(i) < cnt)
                ext[i] = acc[i];
            else if (3'(i) == cnt)
                ext[i] = byte_early;
            else if (3'(i) == cnt + 3'd1)
                ext[i] = byte_late;
        end
        n      = cnt + 3'd2;
        emit   = in_valid && (n >= 3'd5);
        // IDLE beats always open a new line, so the first quad flag is forced
        fq_eff = (state == IDLE) ? 1'b1 : first_quad;
        quad   = '0;
        for (int k = 0; k < 4; k++)
            quad[10*k +: 10] = {ext[k], ext[4][2*k +: 2]};
    end

    // Line FSM, byte accumulator and registered pixel/status outputs.
    always_ff @(posedge rxbyteclkhs) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            first_quad <= 1'b1;
            for (int i = 0; i < 4; i++) acc[i] <= 8'h00;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_sol    <= 1'b0;
            pix_eof    <= 1'b0;
            resid_err  <= 1'b0;
`ifdef RAW10_LINE_CNT_EN
            quad_cnt   <= '0;
            line_quads <= '0;
            line_done  <= 1'b0;
`endif
        end else begin
            pix_valid <= 1'b0;
            pix_sol   <= 1'b0;
            pix_eof   <= 1'b0;
            resid_err <= 1'b0;
`ifdef RAW10_LINE_CNT_EN
            line_done <= 1'b0;
`endif
            if (in_valid) begin
                state <= LINE;
`ifdef RAW10_LINE_CNT_EN
                // the opening beat of a line never completes a group
                if (state == IDLE) quad_cnt <= '0;
                else if (emit)     quad_cnt <= quad_cnt + 16'd1;
`endif
                if (emit) begin
                    pix_data   <= quad;
                    pix_valid  <= 1'b1;
                    pix_sol    <= fq_eff;
                    pix_eof    <= in_last;
                    first_quad <= 1'b0;
                    acc[0]     <= ext[5];
                    cnt        <= n - 3'd5;
                end else begin
                    for (int i = 0; i < 4; i++) acc[i] <= ext[i];
                    first_quad <= fq_eff;
                    cnt        <= n;
                end
            end else if (state == LINE) begin
                // a lone leftover byte is odd-length padding; more is an error
                state     <= IDLE;
                cnt       <= 3'd0;
                resid_err <= (cnt >= 3'd2);
`ifdef RAW10_LINE_CNT_EN
                line_quads <= quad_cnt;
                line_done  <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_raw10_unpacker.sv
// Scoreboard bench for raw10_unpacker: stimulus pushes hand-computed quads
// and resid_err cycles into queues, a negedge monitor pops and compares.
module tb_raw10_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_stream = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [39:0] pix_data;
    logic        pix_valid, pix_sol, pix_eof, resid_err;
`ifdef RAW10_LINE_CNT_EN
    logic [15:0] line_quads;
    logic [0:0]  line_done;
`endif

    raw10_unpacker #(.DATA_STREAM_WIDTH(16), .LOW_BYTE_FIRST(1'b1)) dut (
        .rxbyteclkhs(clk),
        .reset(reset),
        .in_stream(in_stream),
        .in_valid(in_valid),
        .in_last(in_last),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_sol(pix_sol),
        .pix_eof(pix_eof),
        .resid_err(resid_err)
`ifdef RAW10_LINE_CNT_EN
        ,
        .line_quads(line_quads),
        .line_done(line_done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] d;
        logic        sol;
        logic        eof;
        int          c;
    } exp_t;

    exp_t q[$];
    int   rq[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] pk(input logic [9:0] p3, p2, p1, p0);
        return {p3, p2, p1, p0};
    endfunction

    // drive one beat; when it completes a group, queue the expected quad
    task automatic beat(input logic [15:0] d, input logic last, input bit em,
                        input logic [39:0] ed, input logic es, input logic ee);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_stream = d; in_last = last;
        if (em) begin
            e.d = ed; e.sol = es; e.eof = ee; e.c = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic beat_n(input logic [15:0] d);
        beat(d, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit rexp);
        @(posedge clk); #1;
        in_valid = 1'b0; in_stream = '0; in_last = 1'b0;
        if (rexp) rq.push_back(cyc + 1);
    endtask

    // monitor: compare every strobe against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (pix_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_quad", {24'h0, pix_data}, 64'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("quad_data", {24'h0, pix_data}, {24'h0, e.d});
                    chk("quad_sol", {63'h0, pix_sol}, {63'h0, e.sol});
                    chk("quad_eof", {63'h0, pix_eof}, {63'h0, e.eof});
                    chk("quad_cycle", 64'(cyc), 64'(e.c));
                end
            end else begin
                chk("idle_sol_eof", {62'h0, pix_sol, pix_eof}, 64'h0);
            end
            if (resid_err) begin
                if (rq.size() == 0) chk("unexpected_resid", 64'h1, 64'h0);
                else chk("resid_cycle", 64'(cyc), 64'(rq.pop_front()));
            end
        end
    end

    initial begin
        logic [39:0] qa, qb, qc, qd;
        qa = pk(10'h00C, 10'h008, 10'h005, 10'h000);   // bytes 00..04
        qb = pk(10'h020, 10'h01C, 10'h01A, 10'h015);   // bytes 05..09
        qc = pk(10'h04C, 10'h049, 10'h045, 10'h040);   // bytes 10..14
        qd = pk(10'h060, 10'h05D, 10'h05A, 10'h055);   // bytes 15..19

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_data", {24'h0, pix_data}, 64'h0);
        chk("rst_flags", {60'h0, pix_valid, pix_sol, pix_eof, resid_err}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;
        idle(0);

        // line of bytes 00..09: quads after beats 3 and 5
        beat_n(16'h0100);
        beat_n(16'h0302);
        beat(16'h0504, 1'b0, 1'b1, qa, 1'b1, 1'b0);
        beat_n(16'h0706);
        beat(16'h0908, 1'b0, 1'b1, qb, 1'b0, 1'b0);
        idle(0);
        idle(0);

        // 6 bytes all FF..., 1 padding byte left: no resid_err
        beat_n(16'hFFFF);
        beat_n(16'hFFFF);
        beat(16'h00FF, 1'b0, 1'b1, 40'hFF_FFFF_FFFF, 1'b1, 1'b0);
        idle(0);
        idle(0);

        // 80,40,20,10,E4 then 3 extra bytes: resid_err after the line
        beat_n(16'h4080);
        beat_n(16'h1020);
        beat(16'h11E4, 1'b0, 1'b1, pk(10'h043, 10'h082, 10'h101, 10'h200), 1'b1, 1'b0);
        beat_n(16'h3322);
        idle(1);   // single idle cycle, next line starts immediately

        // final line, in_last on beat 5: second quad carries eof
        beat_n(16'h0100);
        beat_n(16'h0302);
        beat(16'h0504, 1'b0, 1'b1, qa, 1'b1, 1'b0);
        beat_n(16'h0706);
        beat(16'h0908, 1'b1, 1'b1, qb, 1'b0, 1'b1);
        idle(0);
        idle(0);

        // in_last on beat 4 does not complete a group: no eof anywhere
        beat_n(16'h0100);
        beat_n(16'h0302);
        beat(16'h0504, 1'b0, 1'b1, qa, 1'b1, 1'b0);
        beat(16'h0706, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        beat(16'h0908, 1'b0, 1'b1, qb, 1'b0, 1'b0);
        idle(0);
        idle(0);

        // reset after two beats; the reset-cycle beat is ignored
        beat_n(16'hAAAA);
        beat_n(16'hBBBB);
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b1; in_stream = 16'hCCCC;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; in_stream = '0;
        beat_n(16'h1110);
        beat_n(16'h1312);
        beat(16'h1514, 1'b0, 1'b1, qc, 1'b1, 1'b0);
        beat_n(16'h1716);
        beat(16'h1918, 1'b0, 1'b1, qd, 1'b0, 1'b0);
        idle(0);
        idle(0);

`ifdef RAW10_LINE_CNT_EN
        // 10 beats = 20 bytes = 4 quads
        for (int i = 1; i <= 10; i++) begin
            if (i == 3 || i == 5 || i == 8 || i == 10)
                beat(16'h0000, 1'b0, 1'b1, 40'h0, (i == 3), 1'b0);
            else
                beat_n(16'h0000);
        end
        idle(0);
        @(posedge clk);
        @(negedge clk);
        chk("line_done", {63'h0, line_done}, 64'h1);
        chk("line_quads", {48'h0, line_quads}, 64'd4);
        @(negedge clk);
        chk("line_done_pulse", {63'h0, line_done}, 64'h0);
`endif

        repeat (4) idle(0);
        @(negedge clk);
        chk("quads_pending", 64'(q.size()), 64'h0);
        chk("resid_pending", 64'(rq.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
